// File: rtl/cv32e40n_data_xbar_arbiter_if.sv
// Handshake bundle between the CPU/NVPE masters, the crossbar and the arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding system's.
interface cv32e40n_data_xbar_arbiter_if;
  logic m1_req_i;
  logic m2_req_i;
  logic m1_req_o;
  logic m2_req_o;
  logic s1_gnt_i;
  logic s1_rvalid_i;
  logic xbar_master_sel_o;
  logic busy_o;
  logic protocol_err_o;

  modport slave (
    input  m1_req_i, m2_req_i, s1_gnt_i, s1_rvalid_i,
    output m1_req_o, m2_req_o, xbar_master_sel_o, busy_o, protocol_err_o
  );

  modport master (
    output m1_req_i, m2_req_i, s1_gnt_i, s1_rvalid_i,
    input  m1_req_o, m2_req_o, xbar_master_sel_o, busy_o, protocol_err_o
  );
endinterface

// File: rtl/cv32e40n_data_xbar_arbiter.sv
// Owner-select arbiter for the CPU/NVPE data crossbar: gates master requests, caps outstanding
// transactions and hands ownership over only when the current owner is quiescent.
module cv32e40n_data_xbar_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned MAX_BURST       = 8
) (
  input logic                         clk_i,
  input logic                         rst_ni,
  cv32e40n_data_xbar_arbiter_if.slave bus
);

  localparam int unsigned OutW   = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned BurstW = $clog2(MAX_BURST + 1);
  localparam logic [OutW-1:0]   OutMax   = OutW'(MAX_OUTSTANDING);
  localparam logic [BurstW-1:0] BurstMax = BurstW'(MAX_BURST);

  typedef enum logic {StGrant, StDrain} state_e;

  state_e            state_q, state_d;
  logic              sel_q, sel_d;
  logic [OutW-1:0]   out_cnt_q, out_cnt_d;
  logic [BurstW-1:0] burst_cnt_q, burst_cnt_d;
  logic              err_q, err_d;

  logic own_req, oth_req, fwd, m1_gated, m2_gated, accept;

  always_comb begin
    own_req  = sel_q ? bus.m2_req_i : bus.m1_req_i;
    oth_req  = sel_q ? bus.m1_req_i : bus.m2_req_i;
    fwd      = (state_q == StGrant) && (out_cnt_q < OutMax);
    m1_gated = !sel_q && fwd && bus.m1_req_i;
    m2_gated = sel_q && fwd && bus.m2_req_i;
    accept   = (m1_gated || m2_gated) && bus.s1_gnt_i;
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    out_cnt_d   = out_cnt_q;
    burst_cnt_d = burst_cnt_q;
    err_d       = err_q;

    // A response with nothing outstanding is a protocol violation; the count stays at zero.
    if (bus.s1_rvalid_i && (out_cnt_q == '0)) begin
      err_d = 1'b1;
    end
    if (accept && !bus.s1_rvalid_i) begin
      out_cnt_d = out_cnt_q + OutW'(1);
    end else if (!accept && bus.s1_rvalid_i && (out_cnt_q != '0)) begin
      out_cnt_d = out_cnt_q - OutW'(1);
    end

    if (!oth_req) begin
      burst_cnt_d = '0;
    end else if (accept && (burst_cnt_q != BurstMax)) begin
      burst_cnt_d = burst_cnt_q + BurstW'(1);
    end

    unique case (state_q)
      StGrant: begin
        // Safe point: the owner has nothing pending ungranted after this cycle.
        if (oth_req && (!own_req || accept) && (!own_req || (burst_cnt_d == BurstMax))) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (out_cnt_d == '0) begin
          sel_d       = !sel_q;
          burst_cnt_d = '0;
          state_d     = StGrant;
        end
      end
      default: state_d = StGrant;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StGrant;
      sel_q       <= 1'b0;
      out_cnt_q   <= '0;
      burst_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      out_cnt_q   <= out_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      err_q       <= err_d;
    end
  end

  assign bus.m1_req_o          = m1_gated;
  assign bus.m2_req_o          = m2_gated;
  assign bus.xbar_master_sel_o = sel_q;
  assign bus.busy_o            = (out_cnt_q != '0);
  assign bus.protocol_err_o    = err_q;

endmodule

// File: tb/tb_cv32e40n_data_xbar_arbiter.sv
// Self-checking bench for cv32e40n_data_xbar_arbiter: directed scenarios plus a randomized run
// compared cycle by cycle against a transaction-level reference model.
module tb_cv32e40n_data_xbar_arbiter;

  localparam int MAXO = 2;
  localparam int MAXB = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  cv32e40n_data_xbar_arbiter_if bus ();

  cv32e40n_data_xbar_arbiter #(
    .MAX_OUTSTANDING(MAXO),
    .MAX_BURST      (MAXB)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  // Reference model: owner id, "handing over" flag, outstanding and burst counts.
  int owner = 0;
  bit handing = 0;
  int outstanding = 0;
  int burst = 0;
  bit err_seen = 0;
  bit acc1 = 0, acc2 = 0;

  function automatic bit may_forward();
    return !handing && (outstanding < MAXO);
  endfunction

  function automatic bit exp_m1();
    return (owner == 0) && may_forward() && bus.m1_req_i;
  endfunction

  function automatic bit exp_m2();
    return (owner == 1) && may_forward() && bus.m2_req_i;
  endfunction

  // Advance one clock; the model consumes the inputs present at the edge.
  task automatic tick();
    bit own, oth, acc;
    @(posedge clk);
    if (!rst_n) begin
      owner = 0; handing = 0; outstanding = 0; burst = 0; err_seen = 0; acc1 = 0; acc2 = 0;
    end else begin
      own  = (owner == 0) ? bus.m1_req_i : bus.m2_req_i;
      oth  = (owner == 0) ? bus.m2_req_i : bus.m1_req_i;
      acc1 = exp_m1() && bus.s1_gnt_i;
      acc2 = exp_m2() && bus.s1_gnt_i;
      acc  = acc1 || acc2;
      if (bus.s1_rvalid_i && outstanding == 0) err_seen = 1;
      if (acc && !bus.s1_rvalid_i) outstanding++;
      else if (!acc && bus.s1_rvalid_i && outstanding > 0) outstanding--;
      if (!oth) burst = 0;
      else if (acc && burst < MAXB) burst++;
      if (!handing) begin
        if (oth && (!own || acc) && (!own || burst == MAXB)) handing = 1;
      end else if (outstanding == 0) begin
        owner = 1 - owner; handing = 0; burst = 0;
      end
    end
    #1;
  endtask

  task automatic drive(input bit r1, input bit r2, input bit g, input bit rv);
    bus.m1_req_i = r1; bus.m2_req_i = r2; bus.s1_gnt_i = g; bus.s1_rvalid_i = rv;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0);
    rst_n = 0; tick(); rst_n = 1;
  endtask

  task automatic test_reset();
    drive(1, 1, 0, 0);
    rst_n = 0; tick(); tick();
    checks += 5;
    if (bus.xbar_master_sel_o !== 1'b0) begin failures++; $display("FAIL reset_sel got %b exp 0", bus.xbar_master_sel_o); end
    if (bus.m2_req_o !== 1'b0) begin failures++; $display("FAIL reset_m2_req got %b exp 0", bus.m2_req_o); end
    if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got %b exp 0", bus.busy_o); end
    if (bus.protocol_err_o !== 1'b0) begin failures++; $display("FAIL reset_err got %b exp 0", bus.protocol_err_o); end
    if (bus.m1_req_o !== 1'b1) begin failures++; $display("FAIL reset_m1_follow got %b exp 1", bus.m1_req_o); end
    rst_n = 1; #1;
    checks++;
    if (bus.m1_req_o !== 1'b1) begin failures++; $display("FAIL post_reset_m1 got %b exp 1", bus.m1_req_o); end
  endtask

  task automatic test_outstanding_cap();
    do_reset();
    drive(1, 0, 1, 0);
    tick(); tick();
    #1;
    checks += 2;
    if (bus.m1_req_o !== 1'b0) begin failures++; $display("FAIL cap_gated got %b exp 0", bus.m1_req_o); end
    if (bus.busy_o !== 1'b1) begin failures++; $display("FAIL cap_busy got %b exp 1", bus.busy_o); end
    drive(1, 0, 0, 1);
    tick();
    drive(1, 0, 0, 0);
    #1;
    checks++;
    if (bus.m1_req_o !== 1'b1) begin failures++; $display("FAIL cap_release got %b exp 1", bus.m1_req_o); end
  endtask

  task automatic test_idle_switch();
    do_reset();
    drive(0, 0, 0, 0);
    tick();
    drive(0, 1, 0, 0);
    #1;
    checks += 2;
    if (bus.m2_req_o !== 1'b0) begin failures++; $display("FAIL sw_T_m2 got %b exp 0", bus.m2_req_o); end
    if (bus.xbar_master_sel_o !== 1'b0) begin failures++; $display("FAIL sw_T_sel got %b exp 0", bus.xbar_master_sel_o); end
    tick(); #1;
    checks += 2;
    if (bus.xbar_master_sel_o !== 1'b0) begin failures++; $display("FAIL sw_T1_sel got %b exp 0", bus.xbar_master_sel_o); end
    if (bus.m2_req_o !== 1'b0) begin failures++; $display("FAIL sw_T1_m2 got %b exp 0", bus.m2_req_o); end
    tick(); #1;
    checks += 2;
    if (bus.xbar_master_sel_o !== 1'b1) begin failures++; $display("FAIL sw_T2_sel got %b exp 1", bus.xbar_master_sel_o); end
    if (bus.m2_req_o !== 1'b1) begin failures++; $display("FAIL sw_T2_m2 got %b exp 1", bus.m2_req_o); end
  endtask

  task automatic test_fairness();
    int  seg = 0;
    int  m1_seg0 = 0, m2_seg1 = 0, m1_seg2 = 0;
    bit  prev_sel = 0;
    bit  a1, a2;
    do_reset();
    drive(1, 1, 1, 0);
    for (int cyc = 0; cyc < 80 && seg < 3; cyc++) begin
      #1;
      if (bus.xbar_master_sel_o !== prev_sel) begin seg++; prev_sel = bus.xbar_master_sel_o; end
      a1 = bus.m1_req_o && bus.s1_gnt_i;
      a2 = bus.m2_req_o && bus.s1_gnt_i;
      if (seg == 0 && a1) m1_seg0++;
      if (seg == 1 && a2) m2_seg1++;
      if (seg == 2 && a1) m1_seg2++;
      tick();
      bus.s1_rvalid_i = a1 || a2;
    end
    checks += 3;
    if (m1_seg0 != MAXB) begin failures++; $display("FAIL fair_cpu_burst got %0d exp %0d", m1_seg0, MAXB); end
    if (m2_seg1 != MAXB) begin failures++; $display("FAIL fair_nvpe_burst got %0d exp %0d", m2_seg1, MAXB); end
    if (seg < 3) begin failures++; $display("FAIL fair_alternation got %0d switches exp 3", seg); end
  endtask

  task automatic test_no_drop();
    bit flipped = 0;
    do_reset();
    drive(1, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick(); #1;
      checks += 3;
      if (bus.m1_req_o !== 1'b1) begin failures++; $display("FAIL nodrop_m1 cyc %0d got %b exp 1", i, bus.m1_req_o); end
      if (bus.xbar_master_sel_o !== 1'b0) begin failures++; $display("FAIL nodrop_sel cyc %0d got %b exp 0", i, bus.xbar_master_sel_o); end
      if (bus.m2_req_o !== 1'b0) begin failures++; $display("FAIL nodrop_m2 cyc %0d got %b exp 0", i, bus.m2_req_o); end
    end
    drive(1, 1, 1, 0);
    tick();
    drive(0, 1, 0, 0);
    tick();
    drive(0, 1, 0, 1);
    for (int i = 0; i < 6 && !flipped; i++) begin
      tick();
      bus.s1_rvalid_i = 0;
      if (bus.xbar_master_sel_o === 1'b1) flipped = 1;
    end
    checks++;
    if (!flipped) begin failures++; $display("FAIL nodrop_switch got sel=%b exp 1", bus.xbar_master_sel_o); end
  endtask

  task automatic test_err_and_reset();
    do_reset();
    drive(0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0);
    checks++;
    if (bus.protocol_err_o !== 1'b1) begin failures++; $display("FAIL err_set got %b exp 1", bus.protocol_err_o); end
    tick(); tick();
    checks++;
    if (bus.protocol_err_o !== 1'b1) begin failures++; $display("FAIL err_sticky got %b exp 1", bus.protocol_err_o); end
    drive(1, 0, 1, 0);
    tick();
    drive(0, 1, 0, 0);
    tick();
    bus.m1_req_i = 1; #1;
    checks += 3;
    if (bus.busy_o !== 1'b1) begin failures++; $display("FAIL drain_busy got %b exp 1", bus.busy_o); end
    if (bus.m1_req_o !== 1'b0) begin failures++; $display("FAIL drain_m1_gated got %b exp 0", bus.m1_req_o); end
    if (bus.m2_req_o !== 1'b0) begin failures++; $display("FAIL drain_m2_gated got %b exp 0", bus.m2_req_o); end
    rst_n = 0; tick();
    checks += 5;
    if (bus.xbar_master_sel_o !== 1'b0) begin failures++; $display("FAIL mrst_sel got %b exp 0", bus.xbar_master_sel_o); end
    if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL mrst_busy got %b exp 0", bus.busy_o); end
    if (bus.protocol_err_o !== 1'b0) begin failures++; $display("FAIL mrst_err got %b exp 0", bus.protocol_err_o); end
    if (bus.m1_req_o !== 1'b1) begin failures++; $display("FAIL mrst_m1 got %b exp 1", bus.m1_req_o); end
    if (bus.m2_req_o !== 1'b0) begin failures++; $display("FAIL mrst_m2 got %b exp 0", bus.m2_req_o); end
    rst_n = 1;
  endtask

  task automatic test_random();
    bit r1 = 0, r2 = 0, g, rv;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      // Masters keep a raw request up until it is accepted.
      r1 = (r1 && !acc1) ? 1'b1 : ($urandom_range(0, 3) != 0);
      r2 = (r2 && !acc2) ? 1'b1 : ($urandom_range(0, 2) != 0);
      g  = ($urandom_range(0, 3) != 0);
      rv = (outstanding > 0) && ($urandom_range(0, 1) == 1);
      drive(r1, r2, g, rv);
      #1;
      checks += 5;
      if (bus.m1_req_o !== exp_m1()) begin failures++; $display("FAIL rnd_m1 cyc %0d got %b exp %b", cyc, bus.m1_req_o, exp_m1()); end
      if (bus.m2_req_o !== exp_m2()) begin failures++; $display("FAIL rnd_m2 cyc %0d got %b exp %b", cyc, bus.m2_req_o, exp_m2()); end
      if (bus.xbar_master_sel_o !== owner[0]) begin failures++; $display("FAIL rnd_sel cyc %0d got %b exp %0d", cyc, bus.xbar_master_sel_o, owner); end
      if (bus.busy_o !== (outstanding != 0)) begin failures++; $display("FAIL rnd_busy cyc %0d got %b exp %0d", cyc, bus.busy_o, outstanding); end
      if (bus.protocol_err_o !== err_seen) begin failures++; $display("FAIL rnd_err cyc %0d got %b exp %b", cyc, bus.protocol_err_o, err_seen); end
      tick();
    end
  endtask

  initial begin
    drive(0, 0, 0, 0);
    test_reset();
    test_outstanding_cap();
    test_idle_switch();
    test_fairness();
    test_no_drop();
    test_err_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
